// File: rtl/stopwatch_counter_if.sv
// Purpose : groups the button pulses and display-side outputs of the stopwatch.
// Ports   : trig/lap/clear (pulses in), time_reading/state/complete (registered outs).
// Modports: master drives the pulses (board top / bench), slave is the stopwatch.
interface stopwatch_counter_if;
   logic        trig;
   logic        lap;
   logic        clear;
   logic [15:0] time_reading;
   logic [3:0]  state;
   logic        complete;

   modport master (
      output trig, lap, clear,
      input  time_reading, state, complete
   );

   modport slave (
      input  trig, lap, clear,
      output time_reading, state, complete
   );
endinterface

// File: rtl/stopwatch_counter.sv
// Purpose : BCD mm:ss count-up stopwatch with start/pause, lap freeze, clear, 59:59 saturation.
// Latency : every output is registered; a pulse sampled at edge E is reflected right after E.
// Backpr. : none; pulses are single-cycle and consumed (or ignored) on the edge they are seen.
// Ports   : clk, reset (sync, active-high), sw (slave modport: trig/lap/clear in,
//           time_reading[15:0] = {min_tens,min_units,sec_tens,sec_units}, state[3:0], complete out).
module stopwatch_counter #(
   parameter int TICKS_PER_SEC = 100000000
) (
   input  logic                clk,
   input  logic                reset,
   stopwatch_counter_if.slave  sw
);

   localparam int              PW        = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [15:0]     BCD_FULL  = 16'h5959;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUNNING,
      ST_LAP,
      ST_PAUSED,
      ST_FULL
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   live_q, live_d;
   logic [15:0]   lap_q, lap_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   time_reading_q, time_reading_d;
   logic [3:0]    state_code_q, state_code_d;
   logic          complete_q, complete_d;

   logic          counting;
   logic          tick;

   // One-second BCD increment. The top digit never overflows because the
   // FSM stops counting at 59:59.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) begin
               r[11:8] = v[11:8] + 4'd1;
            end else begin
               r[11:8]  = 4'd0;
               r[15:12] = v[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign counting = (state_q == ST_RUNNING) || (state_q == ST_LAP);
   assign tick     = counting && (presc_q == PRESC_MAX);

   always_comb begin
      state_d = state_q;
      live_d  = live_q;
      lap_d   = lap_q;
      presc_d = presc_q;

      // The prescaler advances on every counting edge, including the edge
      // that pauses, so pause/resume never drops a fraction of a second.
      if (counting) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            live_d = bcd_inc(live_q);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (sw.trig) begin
               state_d = ST_RUNNING;
               presc_d = '0;
            end
         end
         ST_RUNNING: begin
            if (tick && (live_d == BCD_FULL)) begin
               state_d = ST_FULL;
            end else if (sw.trig) begin
               state_d = ST_PAUSED;
            end else if (sw.lap) begin
               state_d = ST_LAP;
               lap_d   = live_d;   // freeze the post-edge value, tick included
            end
         end
         ST_LAP: begin
            if (tick && (live_d == BCD_FULL)) begin
               state_d = ST_FULL;
            end else if (sw.trig) begin
               state_d = ST_PAUSED;
            end else if (sw.lap) begin
               state_d = ST_RUNNING;
            end
         end
         ST_PAUSED: begin
            if (sw.clear) begin
               state_d = ST_IDLE;
               live_d  = '0;
               lap_d   = '0;
               presc_d = '0;
            end else if (sw.trig) begin
               state_d = ST_RUNNING;
            end
         end
         ST_FULL: begin
            if (sw.clear) begin
               state_d = ST_IDLE;
               live_d  = '0;
               lap_d   = '0;
               presc_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are computed from next-state values and registered, so they
      // line up with the state change and have no input-to-output path.
      time_reading_d = (state_d == ST_LAP) ? lap_d : live_d;
      complete_d     = (state_d == ST_FULL);
      case (state_d)
         ST_RUNNING: state_code_d = 4'b1000;
         ST_LAP:     state_code_d = 4'b0010;
         ST_PAUSED:  state_code_d = 4'b0100;
         ST_FULL:    state_code_d = 4'b0100;
         default:    state_code_d = 4'b0001;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         live_q         <= '0;
         lap_q          <= '0;
         presc_q        <= '0;
         time_reading_q <= 16'h0000;
         state_code_q   <= 4'b0001;
         complete_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         live_q         <= live_d;
         lap_q          <= lap_d;
         presc_q        <= presc_d;
         time_reading_q <= time_reading_d;
         state_code_q   <= state_code_d;
         complete_q     <= complete_d;
      end
   end

   assign sw.time_reading = time_reading_q;
   assign sw.state        = state_code_q;
   assign sw.complete     = complete_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose : self-checking bench for stopwatch_counter (TICKS_PER_SEC = 4).
// Latency : outputs checked 1 time unit after each rising edge.
// Backpr. : none; pulses are driven as single-cycle levels between edges.
module tb_stopwatch_counter;

   localparam int T = 4;

   logic clk;
   logic reset;

   stopwatch_counter_if sw_if ();

   stopwatch_counter #(.TICKS_PER_SEC(T)) dut (
      .clk   (clk),
      .reset (reset),
      .sw    (sw_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model: seconds as an integer ----------------
   typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE, M_FULL} mmode_t;
   mmode_t m_mode = M_IDLE;
   int     m_sec = 0, m_frac = 0, m_lapsec = 0;

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic m_zero();
      m_mode = M_IDLE; m_sec = 0; m_frac = 0; m_lapsec = 0;
   endtask

   task automatic mstep(input bit r, input bit t, input bit l, input bit c);
      bit hit_full;
      hit_full = 1'b0;
      if (r) begin
         m_zero();
      end else begin
         case (m_mode)
            M_IDLE: if (t) begin m_mode = M_RUN; m_frac = 0; end
            M_RUN, M_LAP: begin
               m_frac++;
               if (m_frac == T) begin
                  m_frac = 0;
                  m_sec++;
                  hit_full = (m_sec == 59 * 60 + 59);
               end
               if (hit_full) m_mode = M_FULL;
               else if (t) m_mode = M_PAUSE;
               else if (l) begin
                  if (m_mode == M_RUN) begin m_mode = M_LAP; m_lapsec = m_sec; end
                  else m_mode = M_RUN;
               end
            end
            M_PAUSE: if (c) m_zero(); else if (t) m_mode = M_RUN;
            M_FULL:  if (c) m_zero();
            default: m_zero();
         endcase
      end
   endtask

   function automatic logic [3:0] m_code();
      case (m_mode)
         M_RUN:           return 4'b1000;
         M_LAP:           return 4'b0010;
         M_PAUSE, M_FULL: return 4'b0100;
         default:         return 4'b0001;
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".reading"}, sw_if.time_reading,
          (m_mode == M_LAP) ? to_bcd(m_lapsec) : to_bcd(m_sec));
      chk({tag, ".state"}, 16'(sw_if.state), 16'(m_code()));
      chk({tag, ".complete"}, 16'(sw_if.complete), 16'(m_mode == M_FULL));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
   task automatic cyc(input bit r, input bit t, input bit l, input bit c);
      reset = r; sw_if.trig = t; sw_if.lap = l; sw_if.clear = c;
      @(posedge clk);
      mstep(r, t, l, c);
      #1;
      reset = 1'b0; sw_if.trig = 1'b0; sw_if.lap = 1'b0; sw_if.clear = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        r, t, l, c;
      logic [15:0] rd;
      logic [3:0]  st;
      logic        cp;
   } vec_t;

   vec_t vecs[24];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      logic        legal;
      int          prev_sec;

      //            r     t     l     c     reading    state    complete
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0001, 1'b0}; // reset
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0}; // start
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b1000, 1'b0}; // 4th edge after trig
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 4'b0010, 1'b0}; // lap
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b0010, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b0010, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b0010, 1'b0}; // live 0002, frozen
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 4'b1000, 1'b0}; // unfreeze
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 4'b0100, 1'b0}; // trig+lap -> paused
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0001, 1'b0}; // clear+trig -> idle
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0001, 1'b0}; // clear ignored in idle
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b0}; // lap ignored in idle
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0100, 1'b0}; // pause, 1 cycle in
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0100, 1'b0}; // lap ignored paused
      vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0}; // resume
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b1000, 1'b0}; // fraction kept
      vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 4'b0010, 1'b0};
      vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b0}; // reset in lap + pulse

      reset = 1'b0; sw_if.trig = 1'b0; sw_if.lap = 1'b0; sw_if.clear = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         cyc(vecs[i].r, vecs[i].t, vecs[i].l, vecs[i].c);
         chk($sformatf("vec%0d.reading", i), sw_if.time_reading, vecs[i].rd);
         chk($sformatf("vec%0d.state", i), 16'(sw_if.state), 16'(vecs[i].st));
         chk($sformatf("vec%0d.complete", i), 16'(sw_if.complete), 16'(vecs[i].cp));
      end

      // Pause 2 cycles into a second, hold 20 cycles, resume: tick 2 cycles later.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("pause.state", 16'(sw_if.state), 16'(4'b0100));
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 0);
         chk_model("pause_hold");
      end
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk("resume+1.reading", sw_if.time_reading, 16'h0000);
      cyc(0, 0, 0, 0);
      chk("resume+2.reading", sw_if.time_reading, 16'h0001);

      // Lap at 00:03, run 5 s, unfreeze shows 00:08.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
      chk("lap_pre.reading", sw_if.time_reading, 16'h0003);
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 0);
         chk_model("lap_frozen");
      end
      chk("lap_frozen.reading", sw_if.time_reading, 16'h0003);
      chk("lap_frozen.state", 16'(sw_if.state), 16'(4'b0010));
      cyc(0, 0, 1, 0);
      chk("lap_release.reading", sw_if.time_reading, 16'h0008);
      chk("lap_release.state", 16'(sw_if.state), 16'(4'b1000));

      // Full run to 59:59 with carry and digit-range checks.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      prev_sec = m_sec;
      for (int i = 0; i < 15000 && m_mode != M_FULL; i++) begin
         cyc(0, 0, 0, 0);
         chk_model("run");
         rd    = sw_if.time_reading;
         legal = (rd[3:0] <= 4'd9) && (rd[7:4] <= 4'd5) &&
                 (rd[11:8] <= 4'd9) && (rd[15:12] <= 4'd5);
         chk("run.bcd_legal", 16'(legal), 16'd1);
         if (m_sec != prev_sec && m_sec == 10)  chk("carry_10s", rd, 16'h0010);
         if (m_sec != prev_sec && m_sec == 60)  chk("carry_1m", rd, 16'h0100);
         if (m_sec != prev_sec && m_sec == 600) chk("carry_10m", rd, 16'h1000);
         prev_sec = m_sec;
      end
      chk("full.reached", 16'(m_mode == M_FULL), 16'd1);
      chk("full.reading", sw_if.time_reading, 16'h5959);
      chk("full.state", 16'(sw_if.state), 16'(4'b0100));
      chk("full.complete", 16'(sw_if.complete), 16'd1);
      for (int i = 0; i < 44; i++) begin
         cyc(0, (i % 4) == 0, (i % 6) == 3, 0);
         chk("full_hold.reading", sw_if.time_reading, 16'h5959);
         chk("full_hold.complete", 16'(sw_if.complete), 16'd1);
      end
      cyc(0, 0, 0, 1);
      chk("full_clear.reading", sw_if.time_reading, 16'h0000);
      chk("full_clear.state", 16'(sw_if.state), 16'(4'b0001));
      chk("full_clear.complete", 16'(sw_if.complete), 16'd0);

      // Randomized pulses against the model.
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
         chk_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
